// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline port A over long-latency port B with
// starvation relief, a pending-write scoreboard and issue hazard detection.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the writeback value to issue.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [4:0]  a_rd,
   input  logic [31:0] a_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [4:0]  b_rd,
   input  logic [31:0] b_data,
   input  logic        iss_valid,
   input  logic        iss_long,
   input  logic [4:0]  iss_rd,
   input  logic [4:0]  iss_rs1,
   input  logic [4:0]  iss_rs2,
   output logic        hazard_stall,
   output logic        wb_en,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        rs1_fwd_hit,
   output logic        rs2_fwd_hit,
   output logic [31:0] fwd_data
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;
   localparam int unsigned NREG = 32;
   localparam int unsigned CW   = 4;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0]   starve_cnt;
   logic [CW-1:0]   starve_nxt;
   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;
   logic            force_b;
   logic            a_acc;
   logic            b_acc;
   logic            acc_valid;
   logic [RW-1:0]   acc_rd;
   logic [XLEN-1:0] acc_data;
   logic            pend_hit;
   logic            wb_hit;
   logic            iss_set;

   // Arbitration: A wins unless B has waited STARVE_LIMIT cycles.
   assign force_b = (starve_cnt == LIMIT) && b_valid;
   assign a_ready = !force_b;
   assign b_ready = force_b || !a_valid;
   assign a_acc   = a_valid && a_ready;
   assign b_acc   = b_valid && b_ready;

   assign acc_valid = a_acc || b_acc;
   assign acc_rd    = a_acc ? a_rd : b_rd;
   assign acc_data  = a_acc ? a_data : b_data;

   always_comb begin
      starve_nxt = '0;
      if (b_valid && !b_ready) begin
         starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= starve_nxt;
      end
   end

   // Writeback register; index 0 is accepted but never written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else begin
         wb_en <= acc_valid && (acc_rd != '0);
         if (acc_valid) begin
            wb_rd   <= acc_rd;
            wb_data <= acc_data;
         end
      end
   end

   always_comb begin
      pend_hit = 1'b0;
      if (iss_rs1 != '0 && pending[iss_rs1]) pend_hit = 1'b1;
      if (iss_rs2 != '0 && pending[iss_rs2]) pend_hit = 1'b1;
      if (iss_rd  != '0 && pending[iss_rd])  pend_hit = 1'b1;
   end

`ifdef REGFILE_WB_BYPASS_EN
   assign rs1_fwd_hit = wb_en && (wb_rd == iss_rs1) && (iss_rs1 != '0);
   assign rs2_fwd_hit = wb_en && (wb_rd == iss_rs2) && (iss_rs2 != '0);
   assign fwd_data    = wb_data;
   assign wb_hit      = 1'b0;
`else
   assign rs1_fwd_hit = 1'b0;
   assign rs2_fwd_hit = 1'b0;
   assign fwd_data    = '0;
   // Without forwarding, a source matching the in-flight write must wait a cycle.
   assign wb_hit      = wb_en && (((iss_rs1 != '0) && (wb_rd == iss_rs1)) ||
                                  ((iss_rs2 != '0) && (wb_rd == iss_rs2)));
`endif

   assign hazard_stall = iss_valid && (pend_hit || wb_hit);

   assign iss_set = iss_valid && !hazard_stall && iss_long && (iss_rd != '0);

   // Scoreboard update: set after clear so a same-index issue wins.
   always_comb begin
      pending_nxt = pending;
      if (b_acc) pending_nxt[b_rd] = 1'b0;
      if (iss_set) pending_nxt[iss_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
      end else begin
         pending <= pending_nxt;
      end
   end

endmodule
